roll_sequencer: RTL and testbench

- Controller that sequences the lab1 LFSR random-number datapath for one "roll".
- Seeds the LFSR from a free-running counter when start is pressed, then runs a four-phase slow-down schedule that refreshes the 4-bit display less often in each phase.
- Commits the final value into a 4-entry history. The history can be recalled on the display between rolls.
- Sits between the debounced key pulses and the seven-segment decoder.

---
 rtl/roll_sequencer.sv | 145 ++++++++++++++
 tb/tb_roll_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/roll_sequencer.sv
// roll_sequencer: sequences one LFSR "roll" with a four-phase slow-down of the
// display refresh, commits the result to a 4-entry history and replays it on recall.
module roll_sequencer #(
  parameter int PHASE_LEN = 2**24,
  parameter int BASE_DIV  = 2**20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_recall,
  output logic [3:0] o_random_out,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_hist_idx
);

  localparam int PC_W  = $clog2(PHASE_LEN);
  localparam int DIV_W = $clog2(BASE_DIV) + 3;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_RECALL} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [1:0]       phase_q, phase_d;
  logic [PC_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       out_q, out_d;
  logic             done_q, done_d;
  logic [1:0]       hist_idx_q, hist_idx_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       hist_q [4];
  logic [3:0]       hist_d [4];
  logic [2:0]       hist_count_q, hist_count_d;

  logic [15:0]      lfsr_step;
  logic [15:0]      seed;
  logic [DIV_W-1:0] div_last;
  logic             finish;

  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign seed      = lfsr_q ^ cnt_q;
  assign div_last  = DIV_W'((BASE_DIV << phase_q) - 1);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    lfsr_d       = lfsr_q;
    phase_d      = phase_q;
    phase_cnt_d  = phase_cnt_q;
    div_cnt_d    = div_cnt_q;
    out_d        = out_q;
    done_d       = 1'b0;
    hist_idx_d   = hist_idx_q;
    ptr_d        = ptr_q;
    hist_d       = hist_q;
    hist_count_d = hist_count_q;
    finish       = 1'b0;

    case (state_q)
      S_ROLL: begin
        lfsr_d      = lfsr_step;
        phase_cnt_d = phase_cnt_q + PC_W'(1);
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == div_last) begin
          out_d     = lfsr_q[3:0];
          div_cnt_d = '0;
        end
        if (phase_cnt_q == PC_LAST) begin
          phase_cnt_d = '0;
          div_cnt_d   = '0;
          phase_d     = phase_q + 2'd1;
        end
        finish = ((phase_q == 2'd3) && (phase_cnt_q == PC_LAST)) || i_stop;
        if (finish) begin
          out_d     = lfsr_q[3:0];
          hist_d[0] = lfsr_q[3:0];
          for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
          if (hist_count_q != 3'd4) hist_count_d = hist_count_q + 3'd1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        // Start outranks recall; a zero seed would lock the LFSR, so it is replaced.
        if (i_start) begin
          lfsr_d      = (seed == 16'h0000) ? 16'h0001 : seed;
          out_d       = 4'h0;
          phase_d     = 2'd0;
          phase_cnt_d = '0;
          div_cnt_d   = '0;
          hist_idx_d  = 2'd0;
          ptr_d       = 2'd0;
          state_d     = S_ROLL;
        end else if (i_recall && (hist_count_q != 3'd0)) begin
          out_d      = hist_q[ptr_q];
          hist_idx_d = ptr_q;
          ptr_d      = (({1'b0, ptr_q} + 3'd1) == hist_count_q) ? 2'd0 : ptr_q + 2'd1;
          state_d    = S_RECALL;
        end
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= '0;
      phase_q      <= '0;
      phase_cnt_q  <= '0;
      div_cnt_q    <= '0;
      out_q        <= '0;
      done_q       <= 1'b0;
      hist_idx_q   <= '0;
      ptr_q        <= '0;
      hist_count_q <= '0;
      // NOTE: the history is small and must read back as cleared, so it is reset like any flop.
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      phase_q      <= phase_d;
      phase_cnt_q  <= phase_cnt_d;
      div_cnt_q    <= div_cnt_d;
      out_q        <= out_d;
      done_q       <= done_d;
      hist_idx_q   <= hist_idx_d;
      ptr_q        <= ptr_d;
      hist_count_q <= hist_count_d;
      hist_q       <= hist_d;
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = (state_q == S_ROLL);
  assign o_done       = done_q;
  assign o_hist_idx   = hist_idx_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Self-checking bench for roll_sequencer: directed table, hand-written corner
// sequences and randomized traffic against a behavioural roll model.
module tb_roll_sequencer;

  localparam int PL = 16;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, recall = 1'b0;
  logic [3:0] rout;
  logic       busy, done;
  logic [1:0] hidx;

  always #5 clk = ~clk;

  roll_sequencer #(.PHASE_LEN(PL), .BASE_DIV(BD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_recall(recall),
    .o_random_out(rout), .o_busy(busy), .o_done(done), .o_hist_idx(hidx)
  );

  int n_vec = 0, n_err = 0;
  int busy_seen = 0, done_seen = 0;

  // Behavioural model: roll progress is a cycle index, phases/refreshes are derived arithmetically.
  logic [15:0] m_cnt, m_lfsr;
  bit          m_roll, m_done;
  int          m_t, m_ptr;
  logic [3:0]  m_out, m_last;
  logic [1:0]  m_idx;
  logic [3:0]  m_hist[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_lfsr = 0; m_roll = 0; m_done = 0; m_t = 0; m_ptr = 0;
    m_out = 0; m_idx = 0; m_last = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit s, input bit st, input bit r);
    logic [3:0]  cur;
    logic [15:0] sd;
    int ph, pos;
    m_done = 0;
    if (m_roll) begin
      ph  = m_t / PL;
      pos = m_t % PL;
      cur = m_lfsr[3:0];
      if (((pos + 1) % (BD << ph)) == 0) m_out = cur;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      if (m_t == 4*PL - 1 || st) begin
        m_out = cur;
        m_last = cur;
        m_hist.push_front(cur);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        m_done = 1;
        m_roll = 0;
      end else begin
        m_t++;
      end
    end else if (s) begin
      sd = m_lfsr ^ m_cnt;
      m_lfsr = (sd == 0) ? 16'h0001 : sd;
      m_out = 0; m_idx = 0; m_ptr = 0; m_t = 0; m_roll = 1;
    end else if (r && m_hist.size() > 0) begin
      m_out = m_hist[m_ptr];
      m_idx = 2'(m_ptr);
      m_ptr = (m_ptr + 1) % m_hist.size();
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic tick(input bit s = 0, input bit st = 0, input bit r = 0);
    start = s; stop = st; recall = r;
    @(posedge clk);
    model_step(s, st, r);
    #1;
    start = 0; stop = 0; recall = 0;
    if (busy) busy_seen++;
    if (done) done_seen++;
    check("out", 16'(rout), 16'(m_out));
    check("busy", 16'(busy), 16'(m_roll));
    check("done", 16'(done), 16'(m_done));
    check("hist_idx", 16'(hidx), 16'(m_idx));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", 16'(rout), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_idx", 16'(hidx), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic finish_roll(input string name);
    int n = 0;
    while (m_roll && n < 200) begin
      tick();
      n++;
    end
    check(name, 16'(busy), 16'h0);
  endtask

  typedef struct {
    bit         s, st, r;
    logic [3:0] out;
    bit         busy, done;
    logic [1:0] idx;
  } vec_t;

  vec_t       tbl[12];
  logic [3:0] res[5];
  int         exp_idx[6];
  int         bound;

  initial begin
    // Counter value before each edge equals the row index; start at row 5 seeds 0x0005.
    tbl = '{
      '{0,0,0, 4'h0, 0,0, 2'd0},
      '{0,0,0, 4'h0, 0,0, 2'd0},
      '{0,0,1, 4'h0, 0,0, 2'd0},
      '{0,0,0, 4'h0, 0,0, 2'd0},
      '{0,0,0, 4'h0, 0,0, 2'd0},
      '{1,0,0, 4'h0, 1,0, 2'd0},
      '{0,0,0, 4'h0, 1,0, 2'd0},
      '{0,0,0, 4'h2, 1,0, 2'd0},
      '{0,0,0, 4'h2, 1,0, 2'd0},
      '{0,0,0, 4'h0, 1,0, 2'd0},
      '{1,0,1, 4'h0, 1,0, 2'd0},
      '{0,0,0, 4'h0, 1,0, 2'd0}
    };
    exp_idx = '{0, 1, 2, 3, 0, 1};

    // Reset, idle, then reset in the middle of a roll.
    do_reset();
    repeat (10) tick();
    tick(1);
    repeat (20) tick();
    do_reset();

    // Directed table straight after reset; recall at row 2 must be ignored (history empty).
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].s, tbl[i].st, tbl[i].r);
      check($sformatf("tbl%0d_out", i), 16'(rout), 16'(tbl[i].out));
      check($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i), 16'(done), 16'(tbl[i].done));
      check($sformatf("tbl%0d_idx", i), 16'(hidx), 16'(tbl[i].idx));
    end
    finish_roll("full_roll_end");
    repeat (3) tick();
    check("full_roll_busy_cycles", 16'(busy_seen), 16'd64);
    check("full_roll_done_pulses", 16'(done_seen), 16'd1);

    // Zero seed is replaced by 0x0001.
    do_reset();
    tick(1);
    finish_roll("seed1_roll_end");

    // Early stop on the 10th roll cycle.
    busy_seen = 0; done_seen = 0;
    tick(1);
    repeat (9) tick();
    tick(0, 1);
    tick();
    check("stop10_busy_cycles", 16'(busy_seen), 16'd10);
    check("stop10_done_pulses", 16'(done_seen), 16'd1);

    // Stop coinciding with the natural end; start pulses mid-roll are ignored.
    busy_seen = 0; done_seen = 0;
    tick(1);
    for (int i = 0; i < 63; i++) tick(i == 20, 0, i == 30);
    tick(0, 1);
    repeat (2) tick();
    check("stop64_busy_cycles", 16'(busy_seen), 16'd64);
    check("stop64_done_pulses", 16'(done_seen), 16'd1);

    // Five rolls, then six recalls walk newest to oldest and wrap.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1);
      repeat ($urandom_range(40, 3)) tick();
      tick(0, 1);
      res[k] = m_last;
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 1);
      check($sformatf("recall%0d_out", k), 16'(rout), 16'(res[(k < 4) ? 4 - k : 8 - k]));
      check($sformatf("recall%0d_idx", k), 16'(hidx), 16'(exp_idx[k]));
    end

    // Start and recall together from S_RECALL: a roll starts, no recall.
    tick(1, 0, 1);
    check("start_recall_busy", 16'(busy), 16'h1);
    check("start_recall_out", 16'(rout), 16'h0);
    check("start_recall_idx", 16'(hidx), 16'h0);
    finish_roll("start_recall_roll_end");

    // Idle across the counter wrap, then seed right at 0xFFFF.
    bound = 0;
    while (m_cnt != 16'hFFFF && bound < 70000) begin
      tick();
      bound++;
    end
    check("wrap_reached", m_cnt, 16'hFFFF);
    tick(1);
    repeat (3) tick();
    tick(1);
    finish_roll("wrap_roll_end");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
